// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM access arbiter and its address-calculator users.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARB   = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4,
        ST_ADV   = 3'd5,
        ST_DONE  = 3'd6
    } arb_state_t;

    // Calculator pointer selection: 1 selects the read pointer, 0 the write pointer.
    localparam logic MODE_READ  = 1'b1;
    localparam logic MODE_WRITE = 1'b0;

endpackage

// File: rtl/sdram_access_arbiter.sv
// Sequences the SDRAM address calculator and command strobes between one reader and one writer.
// Latency: start -> calc_load next cycle; each unstalled transaction takes 3 cycles (ARB, cmd, ADV).
// Backpressure: mem_waitrequest holds the command state (strobe and calc_mode frozen) until accepted.
module sdram_access_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [CNT_W-1:0] rd_total,
    input  logic [CNT_W-1:0] wr_total,
    input  logic             rd_req,
    input  logic             wr_req,
    output logic             rd_grant,
    output logic             wr_grant,
    output logic             calc_load,
    output logic             calc_mode,
    output logic             calc_enable,
    output logic             mem_read,
    output logic             mem_write,
    input  logic             mem_waitrequest,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] rd_left_q, rd_left_d;
    logic [CNT_W-1:0] wr_left_q, wr_left_d;
    logic             last_rd_q, last_rd_d;
    logic             calc_mode_q, calc_mode_d;

    logic             rd_ok;
    logic             wr_ok;

    // A side may only be chosen while it is requesting and still has work left in the job.
    assign rd_ok = rd_req && (rd_left_q != '0);
    assign wr_ok = wr_req && (wr_left_q != '0);

    // State register, job counters, priority flag and registered calculator mode.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            rd_left_q   <= '0;
            wr_left_q   <= '0;
            last_rd_q   <= 1'b0;
            calc_mode_q <= MODE_READ;
        end else begin
            state_q     <= state_d;
            rd_left_q   <= rd_left_d;
            wr_left_q   <= wr_left_d;
            last_rd_q   <= last_rd_d;
            calc_mode_q <= calc_mode_d;
        end
    end

    // Next-state, counter and priority updates; every register holds by default.
    always_comb begin
        state_d     = state_q;
        rd_left_d   = rd_left_q;
        wr_left_d   = wr_left_q;
        last_rd_d   = last_rd_q;
        calc_mode_d = calc_mode_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rd_left_d = rd_total;
                    wr_left_d = wr_total;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Fresh job: reads get first pick when both sides contend.
                last_rd_d = 1'b0;
                state_d   = ST_ARB;
            end
            ST_ARB: begin
                if ((rd_left_q == '0) && (wr_left_q == '0)) begin
                    state_d = ST_DONE;
                end else if (rd_ok && (!wr_ok || !last_rd_q)) begin
                    calc_mode_d = MODE_READ;
                    state_d     = ST_READ;
                end else if (wr_ok) begin
                    calc_mode_d = MODE_WRITE;
                    state_d     = ST_WRITE;
                end
            end
            ST_READ, ST_WRITE: begin
                if (!mem_waitrequest) begin
                    state_d = ST_ADV;
                end
            end
            ST_ADV: begin
                // The command just accepted is identified by the mode still held from ARB.
                if (calc_mode_q == MODE_READ) begin
                    rd_left_d = rd_left_q - CNT_ONE;
                    last_rd_d = 1'b1;
                end else begin
                    wr_left_d = wr_left_q - CNT_ONE;
                    last_rd_d = 1'b0;
                end
                state_d = ST_ARB;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state and mode only.
    assign calc_load   = (state_q == ST_LOAD);
    assign calc_mode   = calc_mode_q;
    assign calc_enable = (state_q == ST_ADV);
    assign mem_read    = (state_q == ST_READ);
    assign mem_write   = (state_q == ST_WRITE);
    assign rd_grant    = (state_q == ST_ADV) && (calc_mode_q == MODE_READ);
    assign wr_grant    = (state_q == ST_ADV) && (calc_mode_q == MODE_WRITE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);

endmodule
